// File: rtl/vec_mem_sequencer.sv
// Sole owner of the single memory port: arbitrates fetch vs load/store and sequences 1- or NUM_ELEMS-beat transfers.
// Latency: fetch valid at t+3, load done at t+N+2, store done at t+N+1; requesters hold level req until done/valid.
module vec_mem_sequencer #(
    parameter int NUM_ELEMS = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        Clk1,
    input  logic                        Reset,
    input  logic                        fetch_req,
    input  logic [ADDR_W-1:0]           fetch_addr,
    output logic                        fetch_valid,
    output logic [DATA_W-1:0]           fetch_data,
    input  logic                        ls_req,
    input  logic                        ls_we,
    input  logic                        ls_vec,
    input  logic [ADDR_W-1:0]           ls_addr,
    input  logic [NUM_ELEMS*DATA_W-1:0] ls_wdata,
    output logic                        ls_done,
    output logic [NUM_ELEMS*DATA_W-1:0] ls_rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           Addr,
    output logic                        RD,
    output logic                        WR,
    output logic                        V,
    output logic [DATA_W-1:0]           dataOut,
    input  logic [DATA_W-1:0]           DataIn
);
    localparam int BW = $clog2(NUM_ELEMS) + 1;
    localparam int VW = NUM_ELEMS * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_LOAD, S_LDRAIN, S_STORE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              vec_q, vec_d;
    logic              is_fetch_q, is_fetch_d;
    logic [VW-1:0]     wdata_q, wdata_d;
    logic [VW-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [BW-1:0]     last_beat;
    logic [BW-1:0]     cap_idx;

    assign last_beat = vec_q ? BW'(NUM_ELEMS - 1) : '0;
    // Read data lags the address by one beat, so LOAD fills element k-1 and LDRAIN the final one.
    assign cap_idx   = (state_q == S_LDRAIN) ? last_beat : beat_q - BW'(1);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        vec_d       = vec_q;
        is_fetch_d  = is_fetch_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        fdata_d     = fdata_q;
        beat_d      = beat_q;
        Addr        = '0;
        RD          = 1'b0;
        WR          = 1'b0;
        V           = 1'b0;
        dataOut     = '0;
        fetch_valid = 1'b0;
        ls_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (ls_req) begin
                    base_d     = ls_addr;
                    vec_d      = ls_vec;
                    wdata_d    = ls_wdata;
                    is_fetch_d = 1'b0;
                    state_d    = ls_we ? S_STORE : S_LOAD;
                end else if (fetch_req) begin
                    base_d     = fetch_addr;
                    is_fetch_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                Addr    = base_q;
                RD      = 1'b1;
                state_d = S_FWAIT;
            end
            S_FWAIT: begin
                fdata_d = DataIn;
                state_d = S_DONE;
            end
            S_LOAD: begin
                Addr = base_q + ADDR_W'(beat_q);
                RD   = 1'b1;
                V    = vec_q;
                if (beat_q != '0) begin
                    rdata_d[int'(cap_idx)*DATA_W +: DATA_W] = DataIn;
                end
                if (beat_q == last_beat) begin
                    state_d = S_LDRAIN;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_LDRAIN: begin
                if (vec_q) begin
                    rdata_d[int'(cap_idx)*DATA_W +: DATA_W] = DataIn;
                end else begin
                    rdata_d = VW'(DataIn);
                end
                state_d = S_DONE;
            end
            S_STORE: begin
                Addr    = base_q + ADDR_W'(beat_q);
                WR      = 1'b1;
                V       = vec_q;
                dataOut = wdata_q[int'(beat_q)*DATA_W +: DATA_W];
                if (beat_q == last_beat) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_DONE: begin
                fetch_valid = is_fetch_q;
                ls_done     = ~is_fetch_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            vec_q      <= 1'b0;
            is_fetch_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fdata_q    <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            vec_q      <= vec_d;
            is_fetch_q <= is_fetch_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fdata_q    <= fdata_d;
            beat_q     <= beat_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign fetch_data = fdata_q;
    assign ls_rdata   = rdata_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: expected bus beats queued per scenario, popped as strobes appear.
module tb_vec_mem_sequencer;
    logic         Clk1;
    logic         Reset;
    logic         fetch_req;
    logic [15:0]  fetch_addr;
    logic         fetch_valid;
    logic [15:0]  fetch_data;
    logic         ls_req;
    logic         ls_we;
    logic         ls_vec;
    logic [15:0]  ls_addr;
    logic [255:0] ls_wdata;
    logic         ls_done;
    logic [255:0] ls_rdata;
    logic         busy;
    logic [15:0]  Addr;
    logic         RD;
    logic         WR;
    logic         V;
    logic [15:0]  dataOut;
    logic [15:0]  DataIn;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          v;
        logic [15:0] addr;
        logic [15:0] dat;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] mem [0:65535];
    int          vectors;
    int          miscompares;

    vec_mem_sequencer dut (
        .Clk1(Clk1), .Reset(Reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_vec(ls_vec), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .busy(busy), .Addr(Addr), .RD(RD), .WR(WR), .V(V),
        .dataOut(dataOut), .DataIn(DataIn)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    // Memory returns read data one cycle after RD.
    always @(posedge Clk1) begin
        if (RD) DataIn <= mem[Addr];
    end

    task automatic test_reset();
        for (int c = 0; c < 3; c++) @(negedge Clk1);
        vectors++;
        if ({RD, WR, V, busy, fetch_valid, ls_done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes got RD=%b WR=%b V=%b busy=%b fv=%b done=%b want all 0",
                     RD, WR, V, busy, fetch_valid, ls_done);
        end
        vectors++;
        if (Addr !== 16'h0 || dataOut !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus got Addr=%h dataOut=%h want 0000 0000", Addr, dataOut);
        end
        vectors++;
        if (fetch_data !== 16'h0 || ls_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_data got fetch_data=%h ls_rdata=%h want 0", fetch_data, ls_rdata);
        end
        Reset = 1'b0;
    endtask

    task automatic test_fetch();
        beat_t b;
        int    ndone;
        ndone = 0;
        mem[16'h0040] = 16'h1234;
        exp_q.push_back('{rd: 1'b1, wr: 1'b0, v: 1'b0, addr: 16'h0040, dat: 16'h0, cyc: 1});
        @(negedge Clk1);
        fetch_addr = 16'h0040;
        fetch_req  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk1);
            if (c == 1) begin
                fetch_req  = 1'b0;
                fetch_addr = 16'hDEAD;
            end
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL fetch_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr} !== {b.rd, b.wr, b.v, b.addr} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL fetch_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h",
                                 c, RD, WR, V, Addr, b.cyc, b.rd, b.wr, b.v, b.addr);
                    end
                end
            end
            if (fetch_valid) begin
                ndone++;
                vectors++;
                if (c != 3 || fetch_data !== 16'h1234) begin
                    miscompares++;
                    $display("FAIL fetch_valid got cyc=%0d data=%h want cyc=3 data=1234", c, fetch_data);
                end
            end
            if (c == 4) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fetch_busy got busy=%b at t+4 want 0", busy);
                end
            end
        end
        vectors++;
        if (ndone != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fetch_count got pulses=%0d leftover beats=%0d want 1 and 0", ndone, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_vector_load();
        beat_t b;
        int    ndone;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
            exp_q.push_back('{rd: 1'b1, wr: 1'b0, v: 1'b1, addr: 16'h0100 + 16'(i), dat: 16'h0, cyc: i + 1});
        end
        @(negedge Clk1);
        ls_addr = 16'h0100;
        ls_we   = 1'b0;
        ls_vec  = 1'b1;
        ls_req  = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge Clk1);
            if (c == 1) begin
                ls_req  = 1'b0;
                ls_addr = 16'h5555;
                ls_vec  = 1'b0;
            end
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL vload_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr} !== {b.rd, b.wr, b.v, b.addr} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL vload_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h",
                                 c, RD, WR, V, Addr, b.cyc, b.rd, b.wr, b.v, b.addr);
                    end
                end
            end
            if (ls_done) begin
                ndone++;
                vectors++;
                if (c != 18) begin
                    miscompares++;
                    $display("FAIL vload_done got cyc=%0d want cyc=18", c);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (ls_rdata[i*16 +: 16] !== 16'hA000 + 16'(i)) begin
                miscompares++;
                $display("FAIL vload_elem%0d got %h want %h", i, ls_rdata[i*16 +: 16], 16'hA000 + 16'(i));
            end
        end
        vectors++;
        if (ndone != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL vload_count got pulses=%0d leftover beats=%0d want 1 and 0", ndone, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_vector_store_wrap();
        beat_t b;
        int    ndone;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            ls_wdata[i*16 +: 16] = 16'h5000 + 16'(i);
            exp_q.push_back('{rd: 1'b0, wr: 1'b1, v: 1'b1, addr: 16'hFFF8 + 16'(i),
                              dat: 16'h5000 + 16'(i), cyc: i + 1});
        end
        @(negedge Clk1);
        ls_addr = 16'hFFF8;
        ls_we   = 1'b1;
        ls_vec  = 1'b1;
        ls_req  = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge Clk1);
            if (c == 1) begin
                ls_req   = 1'b0;
                ls_wdata = '1;
                ls_addr  = 16'h0;
            end
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL vstore_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr, dataOut} !== {b.rd, b.wr, b.v, b.addr, b.dat} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL vstore_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h dataOut=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h dataOut=%h",
                                 c, RD, WR, V, Addr, dataOut, b.cyc, b.rd, b.wr, b.v, b.addr, b.dat);
                    end
                end
            end
            if (ls_done) begin
                ndone++;
                vectors++;
                if (c != 17) begin
                    miscompares++;
                    $display("FAIL vstore_done got cyc=%0d want cyc=17", c);
                end
            end
        end
        vectors++;
        if (ndone != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL vstore_count got pulses=%0d leftover beats=%0d want 1 and 0", ndone, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_priority();
        beat_t b;
        int    nls;
        int    nfv;
        nls = 0;
        nfv = 0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0080] = 16'h4321;
        exp_q.push_back('{rd: 1'b1, wr: 1'b0, v: 1'b0, addr: 16'h0010, dat: 16'h0, cyc: 1});
        exp_q.push_back('{rd: 1'b1, wr: 1'b0, v: 1'b0, addr: 16'h0080, dat: 16'h0, cyc: 5});
        @(negedge Clk1);
        ls_addr    = 16'h0010;
        ls_we      = 1'b0;
        ls_vec     = 1'b0;
        ls_req     = 1'b1;
        fetch_addr = 16'h0080;
        fetch_req  = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk1);
            if (c == 1) ls_req = 1'b0;
            if (c == 5) fetch_req = 1'b0;
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL prio_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr} !== {b.rd, b.wr, b.v, b.addr} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL prio_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h",
                                 c, RD, WR, V, Addr, b.cyc, b.rd, b.wr, b.v, b.addr);
                    end
                end
            end
            if (ls_done) begin
                nls++;
                vectors++;
                if (c != 3 || ls_rdata !== 256'(16'hBEEF)) begin
                    miscompares++;
                    $display("FAIL prio_ls_done got cyc=%0d rdata=%h want cyc=3 rdata=%h", c, ls_rdata, 256'(16'hBEEF));
                end
            end
            if (fetch_valid) begin
                nfv++;
                vectors++;
                if (c != 7 || fetch_data !== 16'h4321) begin
                    miscompares++;
                    $display("FAIL prio_fetch got cyc=%0d data=%h want cyc=7 data=4321", c, fetch_data);
                end
            end
        end
        vectors++;
        if (nls != 1 || nfv != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL prio_count got ls=%0d fetch=%0d leftover=%0d want 1 1 0", nls, nfv, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        beat_t b;
        int    ndone;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0200 + 16'(i)] = 16'hC000 + 16'(i);
            exp_q.push_back('{rd: 1'b1, wr: 1'b0, v: 1'b1, addr: 16'h0200 + 16'(i), dat: 16'h0, cyc: i + 1});
        end
        @(negedge Clk1);
        ls_addr = 16'h0200;
        ls_we   = 1'b0;
        ls_vec  = 1'b1;
        ls_req  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk1);
            if (c == 1) ls_req = 1'b0;
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rst_load_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr} !== {b.rd, b.wr, b.v, b.addr} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL rst_load_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h",
                                 c, RD, WR, V, Addr, b.cyc, b.rd, b.wr, b.v, b.addr);
                    end
                end
            end
            if (ls_done) ndone++;
        end
        Reset = 1'b1;
        @(negedge Clk1);
        vectors++;
        if ({RD, WR, V, busy, ls_done} !== 5'b0 || Addr !== 16'h0 || ls_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL rst_mid got RD=%b WR=%b V=%b busy=%b done=%b Addr=%h rdata=%h want all 0",
                     RD, WR, V, busy, ls_done, Addr, ls_rdata);
        end
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk1);
            if (ls_done || RD || WR) ndone++;
        end
        vectors++;
        if (ndone != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_no_done got spurious=%0d leftover=%0d want 0 0", ndone, exp_q.size());
        end
        exp_q.delete();

        exp_q.push_back('{rd: 1'b0, wr: 1'b1, v: 1'b0, addr: 16'h0020, dat: 16'h7777, cyc: 1});
        ls_wdata = 256'(16'h7777);
        ls_addr  = 16'h0020;
        ls_we    = 1'b1;
        ls_vec   = 1'b0;
        ls_req   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk1);
            if (c == 1) ls_req = 1'b0;
            if (RD || WR) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sstore_bus unexpected strobe cyc=%0d RD=%b WR=%b Addr=%h", c, RD, WR, Addr);
                end else begin
                    b = exp_q.pop_front();
                    if ({RD, WR, V, Addr, dataOut} !== {b.rd, b.wr, b.v, b.addr, b.dat} || c != b.cyc) begin
                        miscompares++;
                        $display("FAIL sstore_bus got cyc=%0d RD=%b WR=%b V=%b Addr=%h dataOut=%h want cyc=%0d RD=%b WR=%b V=%b Addr=%h dataOut=%h",
                                 c, RD, WR, V, Addr, dataOut, b.cyc, b.rd, b.wr, b.v, b.addr, b.dat);
                    end
                end
            end
            if (ls_done) begin
                ndone++;
                vectors++;
                if (c != 2) begin
                    miscompares++;
                    $display("FAIL sstore_done got cyc=%0d want cyc=2", c);
                end
            end
        end
        vectors++;
        if (ndone != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sstore_count got pulses=%0d leftover=%0d want 1 0", ndone, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        ls_req      = 1'b0;
        ls_we       = 1'b0;
        ls_vec      = 1'b0;
        ls_addr     = '0;
        ls_wdata    = '0;
        DataIn      = '0;
        test_reset();
        test_fetch();
        test_vector_load();
        test_vector_store_wrap();
        test_priority();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
